// File: rtl/stft_pkg.sv
// Shared constants and types for the STFT analysis framer.
package stft_pkg;

    localparam int N_FFT = 2048;
    localparam int HOP   = 512;
    localparam int DW    = 16;
    localparam int IDX_W = $clog2(N_FFT);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        PRIME,
        IDLE,
        EMIT
    } state_t;

endpackage

// File: rtl/hann_rom.sv
// Periodic Hann window ROM, N_FFT x 16 (Q0.16), synchronous read with enable.
// Contents are computed at elaboration: win[n] = round(65535*0.5*(1-cos(2*pi*n/N_FFT))).
module hann_rom
    import stft_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    input  idx_t        addr,
    output logic [15:0] data
);

    function automatic logic [15:0] hann_coef(input int n);
        real r;
        r = 32767.5 * (1.0 - $cos(6.283185307179586 * real'(n) / real'(N_FFT)));
        return 16'($rtoi(r + 0.5));
    endfunction

    logic [15:0] rom [N_FFT];

    for (genvar n = 0; n < N_FFT; n++) begin : g_rom
        localparam logic [15:0] W = hann_coef(n);
        assign rom[n] = W;
    end

    always_ff @(posedge clk) begin
        if (en) data <= rom[addr];
    end

endmodule

// File: rtl/stft_framer.sv
// STFT analysis framer: circular sample buffer, hop-triggered frame emission.
// Define STFT_FRAMER_HANN_EN for the Hann-windowed output; otherwise the window is rectangular.
module stft_framer
    import stft_pkg::*;
#(
    parameter int N_FFT = stft_pkg::N_FFT,
    parameter int HOP   = stft_pkg::HOP,
    parameter int DW    = stft_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] aud_in,
    input  logic                 aud_vld,
    output logic signed [DW-1:0] frm_data,
    output logic                 frm_valid,
    input  logic                 frm_ready,
    output logic                 frm_first,
    output logic                 frm_last,
    output logic                 full,
    output logic                 overrun
);

    localparam int AW = $clog2(N_FFT);
    localparam int HW = $clog2(HOP);

    state_t        state, state_n;
    logic [AW-1:0] wp, wp_nxt, fstart, fstart_n, pend_start, pend_start_n;
    logic [AW-1:0] idx, acc_cnt, rd_addr, wr_ahead;
    logic [HW-1:0] hop_cnt;
    logic          primed, pending, pending_n, rd_act;
    logic          start, ovr_set, trig, advance, issue, beat_acc, last_acc;
    logic          s1_vld, s1_first, s1_last;

    logic signed [DW-1:0] mem [N_FFT];
    logic signed [DW-1:0] rd_q;
    logic signed [DW-1:0] win_out;

    always_comb begin
        wp_nxt   = wp + AW'(1);
        trig     = aud_vld && (hop_cnt == HW'(HOP - 1)) && (primed || wp == AW'(N_FFT - 1));
        advance  = !frm_valid || frm_ready;
        issue    = rd_act && advance;
        beat_acc = frm_valid && frm_ready;
        last_acc = beat_acc && frm_last;
        rd_addr  = fstart + idx;
        wr_ahead = wp - fstart;

        state_n      = state;
        fstart_n     = fstart;
        pending_n    = pending;
        pend_start_n = pend_start;
        start        = 1'b0;
        ovr_set      = 1'b0;

        case (state)
            PRIME: begin
                if (trig) begin
                    state_n  = EMIT;
                    fstart_n = wp_nxt;
                    start    = 1'b1;
                end
            end
            IDLE: begin
                if (pending) begin
                    state_n   = EMIT;
                    fstart_n  = pend_start;
                    pending_n = 1'b0;
                    start     = 1'b1;
                    if (trig) begin
                        pending_n    = 1'b1;
                        pend_start_n = wp_nxt;
                    end
                end else if (trig) begin
                    state_n  = EMIT;
                    fstart_n = wp_nxt;
                    start    = 1'b1;
                end
            end
            EMIT: begin
                if (trig) begin
                    if (!pending) begin
                        pending_n    = 1'b1;
                        pend_start_n = wp_nxt;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
                // writes landing ahead of the accepted beats clobber unread frame entries
                if (wr_ahead > acc_cnt) ovr_set = 1'b1;
                if (last_acc) begin
                    if (pending) begin
                        fstart_n  = pend_start;
                        pending_n = 1'b0;
                        start     = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PRIME;
            wp         <= '0;
            hop_cnt    <= '0;
            primed     <= 1'b0;
            pending    <= 1'b0;
            fstart     <= '0;
            pend_start <= '0;
            rd_act     <= 1'b0;
            idx        <= '0;
            acc_cnt    <= '0;
            s1_vld     <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            frm_data   <= '0;
            frm_valid  <= 1'b0;
            frm_first  <= 1'b0;
            frm_last   <= 1'b0;
            full       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (aud_vld) begin
                wp      <= wp_nxt;
                hop_cnt <= hop_cnt + HW'(1);
                if (wp == AW'(N_FFT - 1)) primed <= 1'b1;
            end

            state      <= state_n;
            fstart     <= fstart_n;
            pending    <= pending_n;
            pend_start <= pend_start_n;
            if (ovr_set) overrun <= 1'b1;

            if (start) begin
                rd_act  <= 1'b1;
                idx     <= '0;
                acc_cnt <= '0;
            end else begin
                if (issue) begin
                    idx <= idx + AW'(1);
                    if (idx == AW'(N_FFT - 1)) rd_act <= 1'b0;
                end
                if (beat_acc) acc_cnt <= acc_cnt + AW'(1);
            end

            if (advance) begin
                s1_vld    <= issue;
                s1_first  <= issue && (idx == '0);
                s1_last   <= issue && (idx == AW'(N_FFT - 1));
                frm_valid <= s1_vld;
                frm_first <= s1_first;
                frm_last  <= s1_last;
                if (s1_vld) frm_data <= win_out;
            end

            if (last_acc) full <= 1'b0;
            else if (advance && s1_vld && s1_first) full <= 1'b1;
        end
    end

    // Read-before-write buffer: a same-address read returns the previous sample
    always_ff @(posedge clk) begin
        if (aud_vld) mem[wp] <= aud_in;
        if (issue) rd_q <= mem[rd_addr];
    end

`ifdef STFT_FRAMER_HANN_EN
    logic [15:0]          win_q;
    logic signed [DW+16:0] prod;
    logic                 unused_prod_bits;

    hann_rom u_hann_rom (
        .clk  (clk),
        .en   (issue),
        .addr (idx),
        .data (win_q)
    );

    assign prod             = rd_q * $signed({1'b0, win_q});
    assign win_out          = prod[DW+15:16];
    assign unused_prod_bits = ^{prod[DW+16], prod[15:0]};
`else
    assign win_out = rd_q;
`endif

endmodule

// File: tb/tb_stft_framer.sv
// Scoreboard bench for stft_framer: priming, hop, backpressure, overrun, reset abort, full scale.
module tb_stft_framer;
    import stft_pkg::*;

    typedef struct {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] aud_in;
    logic          aud_vld;
    logic [DW-1:0] frm_data;
    logic          frm_valid;
    logic          frm_ready;
    logic          frm_first;
    logic          frm_last;
    logic          full;
    logic          overrun;

    int            n_tests = 0;
    int            n_fail = 0;
    int unsigned   scnt = 0;
    int unsigned   frames = 0;
    int unsigned   beats = 0;
    int unsigned   fbeats = 0;
    int unsigned   last_len = 0;
    int unsigned   vld_seen = 0;
    logic [DW-1:0] beat1024 = '0;
    logic [DW-1:0] hold_d;
    bit            sb_on = 1'b1;
    int            hist [8192];
    beat_t         sb [$];

    always #5 clk = ~clk;

    stft_framer #(
        .N_FFT (N_FFT),
        .HOP   (HOP),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .aud_in    (aud_in),
        .aud_vld   (aud_vld),
        .frm_data  (frm_data),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_first (frm_first),
        .frm_last  (frm_last),
        .full      (full),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_val(input int s, input int unsigned n);
`ifdef STFT_FRAMER_HANN_EN
        real    r;
        longint w;
        longint p;
        r = 65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.141592653589793 * real'(n) / real'(N_FFT)));
        w = longint'($rtoi(r + 0.5));
        p = longint'(s) * w;
        return DW'(p >>> 16);
`else
        return DW'(s + 0 * int'(n));
`endif
    endfunction

    task automatic push_frame(input int unsigned base);
        for (int unsigned j = 0; j < N_FFT; j++) begin
            beat_t e;
            e.data  = exp_val(hist[base + j], j);
            e.first = (j == 0);
            e.last  = (j == N_FFT - 1);
            sb.push_back(e);
        end
    endtask

    task automatic feed(input int unsigned n, input bit konst);
        for (int unsigned i = 0; i < n; i++) begin
            int v;
            v = konst ? 32767 : int'(scnt % 65536);
            aud_vld = 1'b1;
            aud_in  = DW'(v);
            hist[scnt] = v;
            scnt++;
            if (sb_on && scnt >= N_FFT && ((scnt - N_FFT) % HOP) == 0)
                push_frame(scnt - N_FFT);
            @(posedge clk);
            #1;
        end
        aud_vld = 1'b0;
    endtask

    task automatic wait_frames(input int unsigned target, input int unsigned budget);
        int unsigned c = 0;
        while (frames < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("frame_count", frames, target);
    endtask

    task automatic wait_beats(input int unsigned n, input int unsigned budget);
        int unsigned c = 0;
        while (fbeats < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("beat_wait", longint'(fbeats >= n), 1);
    endtask

    task automatic check_outputs_zero();
        check("rst_data", frm_data, 0);
        check("rst_valid", frm_valid, 0);
        check("rst_first", frm_first, 0);
        check("rst_last", frm_last, 0);
        check("rst_full", full, 0);
        check("rst_overrun", overrun, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frm_valid) vld_seen++;
            if (frm_valid && frm_ready) begin
                if (sb_on) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", sb.size(), 1);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        check("beat_data", frm_data, e.data);
                        check("beat_first", frm_first, e.first);
                        check("beat_last", frm_last, e.last);
                        check("beat_full", full, 1);
                    end
                end
                if (fbeats == 1024) beat1024 = frm_data;
                beats++;
                if (frm_last) begin
                    last_len = fbeats + 1;
                    fbeats   = 0;
                    frames++;
                end else begin
                    fbeats++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned f0;
        int unsigned b0;
        rst_n     = 1'b0;
        aud_vld   = 1'b0;
        aud_in    = '0;
        frm_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero();
        rst_n = 1'b1;

        // priming and first-frame latency
        feed(N_FFT - 1, 1'b0);
        check("prime_no_valid", vld_seen, 0);
        feed(1, 1'b0);
        check("lat0_valid", frm_valid, 0);
        @(posedge clk); #1;
        check("lat1_valid", frm_valid, 0);
        @(posedge clk); #1;
        check("lat2_valid", frm_valid, 1);
        check("lat2_first", frm_first, 1);
        check("lat2_full", full, 1);
        wait_frames(1, 3000);
        check("f1_len", last_len, N_FFT);
        check("f1_full_low", full, 0);
        check("f1_valid_low", frm_valid, 0);

        // second frame one hop later
        feed(HOP, 1'b0);
        wait_frames(2, 3000);
        check("f2_len", last_len, N_FFT);

        // backpressure stall mid-frame
        feed(HOP, 1'b0);
        wait_beats(300, 1000);
        @(posedge clk); #1;
        frm_ready = 1'b0;
        hold_d = frm_data;
        repeat (10) begin
            @(posedge clk); #1;
            check("stall_valid", frm_valid, 1);
            check("stall_data", frm_data, hold_d);
        end
        frm_ready = 1'b1;
        wait_frames(3, 3000);
        check("f3_len", last_len, N_FFT);
        check("f3_no_overrun", overrun, 0);
        check("f3_sb_empty", sb.size(), 0);

        // overrun: frame start under backpressure, then two more hops
        sb_on = 1'b0;
        frm_ready = 1'b0;
        f0 = frames;
        b0 = beats;
        feed(HOP, 1'b0);
        feed(2 * HOP, 1'b0);
        check("ovr_set", overrun, 1);
        check("ovr_pending", dut.pending, 1);
        frm_ready = 1'b1;
        wait_frames(f0 + 2, 6000);
        check("ovr_beats", beats - b0, 2 * N_FFT);
        repeat (600) @(posedge clk);
        #1;
        check("ovr_no_extra", frames, f0 + 2);
        check("ovr_sticky", overrun, 1);

        // reset mid-frame at beat 700
        feed(HOP, 1'b0);
        wait_beats(700, 2000);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero();
        check("rst_state", int'(dut.state), int'(PRIME));
        sb.delete();
        scnt     = 0;
        fbeats   = 0;
        vld_seen = 0;
        rst_n    = 1'b1;

        // full-scale constant after re-priming
        sb_on = 1'b1;
        f0 = frames;
        feed(N_FFT - 1, 1'b1);
        check("reprime_no_valid", vld_seen, 0);
        feed(1, 1'b1);
        wait_frames(f0 + 1, 3000);
        check("fs_len", last_len, N_FFT);
`ifdef STFT_FRAMER_HANN_EN
        check("fs_beat1024", beat1024, 16'h7FFE);
`else
        check("fs_beat1024", beat1024, 16'h7FFF);
`endif
        check("fs_sb_empty", sb.size(), 0);
        check("fs_no_overrun", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
